// File: rtl/serial_subtractor_32bit_pkg.sv
// Shared types and sizing helpers for the serial subtractor.
// Optional macro SERIAL_SUBTRACTOR_OVERFLOW_EN (see serial_subtractor_32bit.sv).
package serial_subtractor_32bit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit counter to stay legal.
    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_32bit_subtractor_chunk.sv
// Combinational CHUNK-bit subtract with borrow-in and borrow-out.
// Used once by serial_subtractor_32bit, which feeds it one chunk per cycle.
module subtractor_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] diff,
    output logic             bout
);

    // The extra top bit of the widened result is set exactly when the chunk underflows.
    logic [CHUNK:0] wide;

    always_comb begin
        wide = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
        diff = wide[CHUNK-1:0];
        bout = wide[CHUNK];
    end

endmodule

// File: rtl/serial_subtractor_32bit.sv
// Multi-cycle subtractor: Diff = A - B - Bin, CHUNK bits per clock, valid/ready on both sides.
// Define SERIAL_SUBTRACTOR_OVERFLOW_EN to add the signed-overflow output V.
module serial_subtractor_32bit
    import serial_subtractor_32bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             out_valid,
    input  logic             out_ready
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    output logic             V
`endif
);

    localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
    localparam int CNT_W      = count_width(NUM_CHUNKS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS - 1);

    state_t           state, next_state;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             borrow;
    logic [CNT_W-1:0] k;
    logic [CHUNK-1:0] a_chunk, b_chunk, d_chunk;
    logic             chunk_bout;
    logic             accept_in, last_chunk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept_in  = 1'b0;
        last_chunk = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept_in  = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                last_chunk = (k == LAST);
                if (last_chunk) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Select the operand slices for the chunk currently being processed.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (k == CNT_W'(i)) begin
                a_chunk = a_reg[i*CHUNK +: CHUNK];
                b_chunk = b_reg[i*CHUNK +: CHUNK];
            end
        end
    end

    subtractor_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a   (a_chunk),
        .b   (b_chunk),
        .bin (borrow),
        .diff(d_chunk),
        .bout(chunk_bout)
    );

    // Diff and Bout hold their last value outside RUN, so they stay stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            borrow <= 1'b0;
            k      <= '0;
            Diff   <= '0;
            Bout   <= 1'b0;
        end else if (accept_in) begin
            a_reg  <= A;
            b_reg  <= B;
            borrow <= Bin;
            k      <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < NUM_CHUNKS; i++) begin
                if (k == CNT_W'(i)) Diff[i*CHUNK +: CHUNK] <= d_chunk;
            end
            borrow <= chunk_bout;
            if (last_chunk) begin
                Bout <= chunk_bout;
                k    <= '0;
            end else begin
                k <= k + CNT_W'(1);
            end
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    // The final chunk carries the result sign bit, so overflow is resolved on that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            V <= 1'b0;
        end else if (last_chunk) begin
            V <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (d_chunk[CHUNK-1] != a_reg[WIDTH-1]);
        end else if (state == DONE && out_ready) begin
            V <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor_32bit.sv
// Self-checking bench for serial_subtractor_32bit: directed and random operations
// compared against a whole-word arithmetic reference model.
module tb_serial_subtractor_32bit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A, B;
    logic        Bin, in_valid, out_ready;
    logic        in_ready, out_valid, Bout;
    logic [31:0] Diff;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic        V;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_diff;
    logic        exp_bout;
    logic        exp_v;
    int          lat;

    always #5 clk = ~clk;

    serial_subtractor_32bit dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .Bin      (Bin),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Diff     (Diff),
        .Bout     (Bout),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        ,
        .V        (V)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word unsigned subtraction, borrow is the sign of the 33-bit result.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [32:0] full;
        full     = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        exp_diff = full[31:0];
        exp_bout = full[32];
        exp_v    = (a[31] != b[31]) && (exp_diff[31] != a[31]);
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic bin);
        @(negedge clk);
        A = a; B = b; Bin = bin; in_valid = 1'b1;
        model(a, b, bin);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (cycles < 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            cycles++;
        end
    endtask

    task automatic check_result(input string tag);
        check({tag, "_diff"}, Diff, exp_diff);
        check({tag, "_bout"}, {31'd0, Bout}, {31'd0, exp_bout});
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        check({tag, "_v"}, {31'd0, V}, {31'd0, exp_v});
`endif
    endtask

    task automatic accept_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("out_valid_after_accept", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_accept", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic bin);
        start_op(a, b, bin);
        wait_result(lat);
        check({tag, "_latency"}, lat, 32'd4);
        check_result(tag);
        accept_result();
    endtask

    initial begin
        rst = 1'b1; A = '0; B = '0; Bin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_diff", Diff, 32'd0);
        check("reset_bout", {31'd0, Bout}, 32'd0);
        rst = 1'b0;

        run_op("small", 32'h0000_0005, 32'h0000_0003, 1'b0);
        run_op("full_chain", 32'h0000_0000, 32'h0000_0001, 1'b0);
        run_op("bin_cross", 32'h0001_0000, 32'h0000_0000, 1'b1);
        run_op("neg_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0);
        run_op("pos_ovf", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("max_borrow", 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);

        // Backpressure: result must hold, and a stray in_valid must not start anything.
        start_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        wait_result(lat);
        check("bp_latency", lat, 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = (i == 1);
            if (i == 1) begin A = 32'h1; B = 32'h2; end
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check_result("bp_hold");
        end
        accept_result();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_no_stray_op", {31'd0, out_valid}, 32'd0);
        end

        // Reset after two chunks abandons the operation.
        start_op(32'h1234_5678, 32'h0000_0001, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_diff", Diff, 32'd0);
        check("midrst_bout", {31'd0, Bout}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_out_valid", {31'd0, out_valid}, 32'd0);
            check("postrst_in_ready", {31'd0, in_ready}, 32'd1);
        end
        run_op("after_reset", 32'h0000_0010, 32'h0000_0001, 1'b0);

        for (int i = 0; i < 25; i++) begin
            run_op("random", $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
